// File: rtl/mem_result_reader_if.sv
// Memory read port plus downstream valid/ready stream for mem_result_reader.
`default_nettype none

interface mem_result_reader_if #(
  parameter int NDB    = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [NDB-1:0]    mem_data;
  logic [NDB-1:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_addr, mem_rd_en, out_data, out_valid, out_last,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, out_data, out_valid, out_last,
    output mem_data, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_result_reader.sv
// Reads NUM_WORDS words from a synchronous-read memory (address 0 upward)
// and presents them on a valid/ready stream, flagging the last word.
`default_nettype none

module mem_result_reader #(
  parameter int NDB       = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_WORDS = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic          abort,
  output logic               busy,
  output logic               done,
  mem_result_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.out_data  <= NDB'(0);
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= READ;
            ptr           <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b1;
            busy          <= 1'b1;
          end
        end
        READ: begin
          bus.mem_rd_en <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          bus.out_data  <= bus.mem_data;
          bus.out_valid <= 1'b1;
          bus.out_last  <= (ptr == LAST_PTR);
          state         <= SEND;
        end
        SEND: begin
          // Without out_ready everything is held, so the word is neither lost nor re-read.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (ptr == LAST_PTR) begin
              state        <= IDLE;
              ptr          <= '0;
              bus.mem_addr <= '0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              state         <= READ;
              ptr           <= ptr + ADDR_W'(1);
              bus.mem_addr  <= ptr + ADDR_W'(1);
              bus.mem_rd_en <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
